// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Serializes a parallel word onto `dout` as an
//             asynchronous frame: start bit, data bits LSB first, optional
//             parity bit, then one or two stop bits. Every bit lasts
//             CLKS_PER_BIT clocks, which matches the receiver's oversample
//             ratio, so a direct tx->rx loopback needs no extra divider.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - synchronous reset, active low
//             data       - word to transmit, sampled only on handshake
//             data_valid - source presents a word on `data`
//             ready      - transmitter can accept a word this cycle
//             dout       - serial line, idles high
//             busy       - frame in progress
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 dout,
    output logic                 busy
);

    localparam int             CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    // The bit index doubles as the stop-bit counter; 3 bits cover 0..7.
    localparam logic [2:0]     C_IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]     C_STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           C_PAR_INV   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [2:0]           idx_q,   idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q,   par_d;
    logic                 dout_q,  dout_d;
    logic                 busy_q,  busy_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;

    assign bit_end = (cnt_q == C_CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        dout_d  = dout_q;
        busy_d  = busy_q;

        // Baud counter free-runs inside a frame and wraps at each bit boundary.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                dout_d = 1'b1;
                busy_d = 1'b0;
                // ready is high in IDLE, so data_valid alone completes the handshake.
                if (data_valid) begin
                    state_d = S_START;
                    shreg_d = data;
                    par_d   = (^data) ^ C_PAR_INV;
                    dout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    dout_d  = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == C_IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            dout_d  = par_q;
                        end else begin
                            state_d = S_STOP;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        // dout is registered, so present the next bit one shift ahead.
                        shreg_d = shreg_q >> 1;
                        dout_d  = shreg_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    dout_d  = 1'b1;
                end
            end
            S_STOP: begin
                dout_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == C_STOP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                dout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        ready_d = ~busy_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign dout  = dout_q;
    assign busy  = busy_q;
    assign ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx. Three instances:
//             default 8N1, 8E2 (even parity, two stops), 8O1 (odd parity).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       data_valid;
    int         sel;
    int         total = 0;
    int         bad   = 0;

    logic dv0, dv1, dv2;
    logic rdy0, rdy1, rdy2;
    logic dout0, dout1, dout2;
    logic busy0, busy1, busy2;
    logic cur_dout, cur_ready, cur_busy;

    always #5 clk = ~clk;

    // Only the instance under test sees data_valid.
    assign dv0 = data_valid && (sel == 0);
    assign dv1 = data_valid && (sel == 1);
    assign dv2 = data_valid && (sel == 2);

    always_comb begin
        cur_dout  = dout0;
        cur_ready = rdy0;
        cur_busy  = busy0;
        if (sel == 1) begin
            cur_dout  = dout1;
            cur_ready = rdy1;
            cur_busy  = busy1;
        end else if (sel == 2) begin
            cur_dout  = dout2;
            cur_ready = rdy2;
            cur_busy  = busy2;
        end
    end

    uart_tx u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(dv0),
        .ready(rdy0), .dout(dout0), .busy(busy0)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(dv1),
        .ready(rdy1), .dout(dout1), .busy(busy1)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(dv2),
        .ready(rdy2), .dout(dout2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle handshake; leaves the bench one step after the acceptance edge.
    task automatic send(input logic [7:0] d);
        data       = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Checks each bit is held for 16 clocks with busy high, that ready stays low
    // through the last clock of the frame and rises exactly after it.
    // At frame cycle 40, data and data_valid are overwritten with the given values.
    task automatic check_frame(input string tag, input int nbits, input logic [11:0] exp,
                               input logic [7:0] new_data, input logic dv_after);
        int j;
        j = 0;
        for (int b = 0; b < nbits; b++) begin
            int errs;
            errs = 0;
            for (int k = 0; k < 16; k++) begin
                if (cur_dout !== exp[b]) errs++;
                if (cur_busy !== 1'b1) errs++;
                if (b == nbits - 1 && k == 15) chk({tag, "_ready_low_end"}, 32'(cur_ready), 32'd0);
                if (j == 40) begin
                    data       = new_data;
                    data_valid = dv_after;
                end
                j++;
                tick();
            end
            chk($sformatf("%s_bit%0d", tag, b), errs, 0);
        end
        chk({tag, "_ready_after"}, 32'(cur_ready), 32'd1);
        chk({tag, "_busy_after"},  32'(cur_busy),  32'd0);
        chk({tag, "_dout_idle"},   32'(cur_dout),  32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        data       = 8'h00;
        data_valid = 1'b0;
        sel        = 0;
        tick();
        tick();
        chk("rst_dout0",  32'(dout0), 32'd1);
        chk("rst_ready0", 32'(rdy0),  32'd1);
        chk("rst_busy0",  32'(busy0), 32'd0);
        chk("rst_dout1",  32'(dout1), 32'd1);
        chk("rst_ready2", 32'(rdy2),  32'd1);
        rst_n = 1'b1;
        tick();

        // 0x55 8N1: start 0, then 1,0,1,0,1,0,1,0, stop 1; ready back after 160 clocks.
        send(8'h55);
        check_frame("f55", 10, 12'b00_1_01010101_0, 8'h55, 1'b0);

        // Assorted bytes, decoded bit by bit.
        send(8'hA5);
        check_frame("fA5", 10, 12'b00_1_10100101_0, 8'hA5, 1'b0);
        send(8'h00);
        check_frame("f00", 10, 12'b00_1_00000000_0, 8'h00, 1'b0);
        send(8'hFF);
        check_frame("fFF", 10, 12'b00_1_11111111_0, 8'hFF, 1'b0);
        send(8'h3C);
        check_frame("f3C", 10, 12'b00_1_00111100_0, 8'h3C, 1'b0);
        tick();
        chk("idle_no_extra", 32'(busy0), 32'd0);

        // data changes to 0xEE at frame cycle 40; frame must still carry 0x12.
        send(8'h12);
        check_frame("fchg", 10, 12'b00_1_00010010_0, 8'hEE, 1'b0);

        // Back-to-back with data_valid held: 0x00 then 0xFF, one idle cycle between.
        data       = 8'h00;
        data_valid = 1'b1;
        tick();
        data = 8'hFF;
        check_frame("b2b0", 10, 12'b00_1_00000000_0, 8'hFF, 1'b1);
        tick();
        chk("b2b1_start", 32'(cur_dout), 32'd0);
        check_frame("b2b1", 10, 12'b00_1_11111111_0, 8'hFF, 1'b0);
        tick();
        chk("b2b_no_third", 32'(busy0), 32'd0);

        // Even parity, two stops: 0x07 has three ones -> parity 1; 192-clock frame.
        sel = 1;
        send(8'h07);
        check_frame("par_even", 12, 12'b1_1_1_00000111_0, 8'h07, 1'b0);

        // Odd parity: 0x07 -> parity 0.
        sel = 2;
        send(8'h07);
        check_frame("par_odd", 11, 12'b0_1_0_00000111_0, 8'h07, 1'b0);

        // Reset pulse at cycle 70 of a frame.
        sel = 0;
        send(8'h55);
        repeat (69) tick();
        chk("mid_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_dout",  32'(dout0), 32'd1);
        chk("mid_rst_ready", 32'(rdy0),  32'd1);
        chk("mid_rst_busy",  32'(busy0), 32'd0);
        tick();
        chk("mid_rst_stay_idle", 32'(dout0), 32'd1);
        send(8'hA5);
        check_frame("post_rst", 10, 12'b00_1_10100101_0, 8'hA5, 1'b0);

        // Reset and handshake together: reset wins.
        rst_n      = 1'b0;
        data       = 8'h0F;
        data_valid = 1'b1;
        tick();
        rst_n      = 1'b0;
        data_valid = 1'b0;
        rst_n      = 1'b1;
        chk("rst_hs_busy",  32'(busy0), 32'd0);
        chk("rst_hs_ready", 32'(rdy0),  32'd1);
        tick();
        chk("rst_hs_dout", 32'(dout0), 32'd1);
        chk("rst_hs_busy2", 32'(busy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
